pwm_scheduler: RTL and testbench
================================

// Module: pwm_scheduler
// PURPOSE
//  Consumes the five SPI-written config bytes and drives 16 PWM-capable outputs.
//  Double-buffers config in shadow regs; a 3-state FSM commits new config only at a
//  PWM period boundary, so no glitched/short periods. Sits between SPI register bank and pads.
// PARAMETERS
//  PRESCALE  3000  clk cycles per duty tick (>=1); period = 256*PRESCALE clk cycles
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-high reset
//  cfg_out_lo    in   8  output enable, bits 7:0 (SPI addr 0)
//  cfg_out_hi    in   8  output enable, bits 15:8 (SPI addr 1)
//  cfg_pwm_lo    in   8  PWM mode enable, bits 7:0 (SPI addr 2)
//  cfg_pwm_hi    in   8  PWM mode enable, bits 15:8 (SPI addr 3)
//  cfg_duty      in   8  shared duty value (SPI addr 4)
//  cfg_update    in   1  1-clk pulse: a config byte changed; cfg_* stable from that cycle
//  out           out  16 registered outputs
//  period_start  out  1  1-clk pulse at start of each PWM period
//  pending       out  1  high while a config commit awaits the next boundary
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, shadows=0, pre_cnt=0, duty_cnt=0, out=0,
//   period_start=0, pending=0. Deassert synchronous to clk.
//  Counters (RUN/PENDING only): pre_cnt 0..PRESCALE-1; tick = (pre_cnt==PRESCALE-1).
//   duty_cnt 8b, +1 on tick, wraps 255->0. boundary = tick && duty_cnt==255.
//   In IDLE both counters held at 0.
//  FSM:
//   IDLE:    cfg_update -> load shadows from cfg_*, counters=0, period_start=1 next
//            cycle, -> RUN.
//   RUN:     cfg_update && !boundary -> PENDING. cfg_update && boundary -> commit at
//            this boundary, stay RUN. boundary alone -> wrap, stay RUN.
//   PENDING: boundary -> commit (shadows <= live cfg_* sampled that cycle), -> RUN;
//            if cfg_update same cycle, still commit and -> RUN (live values already
//            reflect it). Extra cfg_update while PENDING coalesce (no queue).
//   pending = (state==PENDING), registered with state.
//  Commit: all 40 shadow bits load in one cycle; never partial.
//  Output per bit i (registered, 1 clk after counter/shadow state):
//   !en_out[i] -> 0; en_out[i] && !en_pwm[i] -> 1;
//   en_out[i] && en_pwm[i] -> duty==8'hFF ? 1 : (duty_cnt < duty).
//   duty=0 -> constant 0; duty=N (1..254) -> N ticks high of 256; 0xFF -> constant 1.
//  period_start: 1 for the clk cycle after duty_cnt wraps to 0 (and after IDLE
//   start); aligned with first out update of the new period.
//  Reset mid-period: out drops to 0 immediately (async), pending cleared, next
//   cfg_update restarts from IDLE with fresh period.
//  No combinational path from cfg_* or cfg_update to any output.
// TESTING (bench uses PRESCALE=2 unless noted)
//  1 Reset, no cfg_update for 2000 clk -> out=0, pending=0, period_start never pulses.
//  2 cfg_out_lo=8'h01, cfg_pwm_lo=0, pulse cfg_update -> out=16'h0001 within 2 clk,
//    period_start pulses once, pending stays 0.
//  3 cfg_out_hi=8'h80, cfg_pwm_hi=8'h80, duty=8'h80, update -> out[15] high 256 clk,
//    low 256 clk, period_start every 512 clk; duty=0 -> out[15] never high;
//    duty=8'hFF -> out[15] constant high.
//  4 In RUN with duty=8'h40, at duty_cnt~100 set duty=8'hC0 + pulse update ->
//    pending=1, old 64-tick pulse completes, pending=0 and 192-tick pulse from next
//    period_start.
//  5 cfg_update on exact boundary cycle in RUN -> new config at that period_start,
//    pending never asserts; 3 updates during one period -> one commit, last values.
//  6 Assert rst mid-period with out!=0 -> out=0 same cycle (no clk edge needed);
//    after release, outputs stay 0 until next cfg_update.

Source files
------------

// File: rtl/pwm_scheduler.sv
// pwm_scheduler: 16-output PWM driver with double-buffered config committed only at period boundaries.
module pwm_scheduler #(
  parameter int PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cfg_out_lo,
  input  logic [7:0]  cfg_out_hi,
  input  logic [7:0]  cfg_pwm_lo,
  input  logic [7:0]  cfg_pwm_hi,
  input  logic [7:0]  cfg_duty,
  input  logic        cfg_update,
  output logic [15:0] out,
  output logic        period_start,
  output logic        pending
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_d;
  logic [PW-1:0] pre_cnt;
  logic [7:0] duty_cnt, duty;
  logic [15:0] en_out, en_pwm;
  logic tick, boundary, commit, hi;
  assign tick = pre_cnt == PW'(PRESCALE - 1);
  assign boundary = tick && duty_cnt == 8'hFF;
  assign hi = duty == 8'hFF || duty_cnt < duty;
  always_comb begin
    state_d = state;
    commit = 1'b0;
    case (state)
      IDLE: begin
        commit = cfg_update;
        state_d = cfg_update ? RUN : IDLE;
      end
      RUN: begin
        commit = cfg_update && boundary;
        state_d = cfg_update && !boundary ? PEND : RUN;
      end
      PEND: begin
        commit = boundary;
        state_d = boundary ? RUN : PEND;
      end
      default: state_d = IDLE;
    endcase
  end
  // period_start and out both derive from the counter state of the previous cycle, so they line up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pending <= 1'b0;
      en_out <= '0;
      en_pwm <= '0;
      duty <= '0;
      pre_cnt <= '0;
      duty_cnt <= '0;
      period_start <= 1'b0;
      out <= '0;
    end else begin
      state <= state_d;
      pending <= state_d == PEND;
      if (commit) begin
        en_out <= {cfg_out_hi, cfg_out_lo};
        en_pwm <= {cfg_pwm_hi, cfg_pwm_lo};
        duty <= cfg_duty;
      end
      pre_cnt <= state == IDLE || tick ? '0 : pre_cnt + PW'(1);
      duty_cnt <= state == IDLE ? 8'd0 : duty_cnt + 8'(tick);
      period_start <= state != IDLE && pre_cnt == '0 && duty_cnt == 8'd0;
      out <= en_out & (~en_pwm | {16{hi}});
    end
  end
endmodule

// File: tb/tb_pwm_scheduler.sv
// tb_pwm_scheduler: directed checks of commit timing, duty shapes and async reset with PRESCALE=2.
module tb_pwm_scheduler;
  logic clk = 1'b0, rst = 1'b1, cfg_update = 1'b0;
  logic [7:0] cfg_out_lo = 0, cfg_out_hi = 0, cfg_pwm_lo = 0, cfg_pwm_hi = 0, cfg_duty = 0;
  logic [15:0] out;
  logic period_start, pending;
  int tests = 0, fails = 0;
  int hi, ps, pd;

  pwm_scheduler #(.PRESCALE(2)) dut (
    .clk(clk), .rst(rst), .cfg_out_lo(cfg_out_lo), .cfg_out_hi(cfg_out_hi),
    .cfg_pwm_lo(cfg_pwm_lo), .cfg_pwm_hi(cfg_pwm_hi), .cfg_duty(cfg_duty),
    .cfg_update(cfg_update), .out(out), .period_start(period_start), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
  endtask

  // Advance until period_start; n counts out[15] high samples seen before it.
  task automatic wait_ps(output int n);
    logic got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (period_start) begin
        got = 1'b1;
        break;
      end
      n += int'(out[15]);
    end
    chk("ps_timeout", 32'(got), 1);
  endtask

  // Sample one full period from a period_start cycle, ending on the next one.
  task automatic measure(output int h, output int p);
    h = 0;
    p = 0;
    for (int i = 0; i < 512; i++) begin
      h += int'(out[15]);
      p += int'(period_start);
      step();
    end
  endtask

  initial begin
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_pending", 32'(pending), 0);
    step(3);
    rst = 1'b0;
    ps = 0;
    pd = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      ps += int'(period_start);
      pd += int'(pending) + int'(out != 0);
    end
    chk("idle_ps", 32'(ps), 0);
    chk("idle_out_pending", 32'(pd), 0);

    cfg_out_lo = 8'h01;
    pulse();
    step();
    chk("start_out", 32'(out), 32'h0001);
    chk("start_ps", 32'(period_start), 1);
    ps = 0;
    pd = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      ps += int'(period_start);
      pd += int'(pending);
    end
    chk("start_ps_once", 32'(ps), 0);
    chk("start_pending", 32'(pd), 0);

    cfg_out_hi = 8'h80;
    cfg_pwm_hi = 8'h80;
    cfg_duty = 8'h80;
    pulse();
    chk("d80_pending", 32'(pending), 1);
    wait_ps(hi);
    chk("d80_commit_pending", 32'(pending), 0);
    chk("d80_first", 32'(out), 32'h8001);
    measure(hi, ps);
    chk("d80_high", 32'(hi), 256);
    chk("d80_ps_count", 32'(ps), 1);
    chk("d80_next_ps", 32'(period_start), 1);

    cfg_duty = 8'h00;
    pulse();
    wait_ps(hi);
    measure(hi, ps);
    chk("d00_high", 32'(hi), 0);

    cfg_duty = 8'hFF;
    pulse();
    wait_ps(hi);
    measure(hi, ps);
    chk("dFF_high", 32'(hi), 512);

    cfg_duty = 8'h40;
    pulse();
    wait_ps(hi);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      hi += int'(out[15]);
      step();
    end
    chk("d40_old_pulse", 32'(hi), 128);
    cfg_duty = 8'hC0;
    pulse();
    chk("dC0_pending", 32'(pending), 1);
    wait_ps(hi);
    chk("dC0_no_early", 32'(hi), 0);
    chk("dC0_cleared", 32'(pending), 0);
    measure(hi, ps);
    chk("dC0_high", 32'(hi), 384);

    pd = 0;
    for (int i = 0; i < 510; i++) begin
      pd += int'(pending);
      step();
    end
    cfg_duty = 8'h00;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    pd += int'(pending);
    chk("edge_no_pending", 32'(pd), 0);
    step();
    chk("edge_ps", 32'(period_start), 1);
    chk("edge_new_cfg", 32'(out), 32'h0001);

    step(10);
    cfg_duty = 8'h10;
    pulse();
    step(10);
    cfg_duty = 8'h20;
    pulse();
    step(10);
    cfg_duty = 8'h30;
    cfg_out_lo = 8'h03;
    pulse();
    chk("coal_pending", 32'(pending), 1);
    wait_ps(hi);
    chk("coal_old_dark", 32'(hi), 0);
    chk("coal_lo", 32'(out[7:0]), 32'h03);
    measure(hi, ps);
    chk("coal_high", 32'(hi), 96);

    step(5);
    chk("pre_rst_out", 32'(out), 32'h8003);
    #2 rst = 1'b1;
    #1;
    chk("async_out", 32'(out), 0);
    chk("async_pending", 32'(pending), 0);
    step(2);
    rst = 1'b0;
    ps = 0;
    pd = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      ps += int'(period_start);
      pd += int'(out != 0);
    end
    chk("post_rst_ps", 32'(ps), 0);
    chk("post_rst_out", 32'(pd), 0);
    pulse();
    step();
    chk("restart_ps", 32'(period_start), 1);
    chk("restart_out", 32'(out), 32'h8003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
